// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: IF/ID packet layout, NOP encoding,
// default depth and the pointer type reused by ROB/debug logic.
package fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH = 8;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        valid;
  } IF_ID_PACKET;

  typedef logic [$clog2(FQ_DEPTH)-1:0] FQ_PTR;

  localparam IF_ID_PACKET NOP_PACKET = '{inst: NOP, PC: '0, NPC: '0, valid: 1'b0};

endpackage

// File: rtl/fetch_queue.sv
// Instruction buffer between ifetch and decode. FIFO of IF_ID_PACKETs with a
// valid/ready handshake toward decode and a space-available signal toward
// ifetch. Any PC redirect flushes the whole queue.
// Optional macro FQ_BYPASS_EN: when the queue is empty and decode is ready,
// an incoming packet is forwarded to decode combinationally without storage.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  IF_ID_PACKET      if_packet,
  output logic             fq_ready,
  input  logic             flush,
  output IF_ID_PACKET      id_packet,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  IF_ID_PACKET       mem [DEPTH];
  logic [DEPTH-1:0]  entry_vld;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              ready_en;
  logic              push;
  logic              pop;
  logic              bypass;

  // Status, handshake and head-entry presentation.
  // fq_ready depends only on registered state and flush, never on id_ready.
  always_comb begin
    full     = (count == CNT_W'(DEPTH));
    empty    = (count == '0);
    fq_ready = ready_en && !full && !flush;
`ifdef FQ_BYPASS_EN
    bypass   = empty && if_packet.valid && fq_ready && id_ready;
`else
    bypass   = 1'b0;
`endif
    push      = if_packet.valid && fq_ready && !bypass;
    id_valid  = 1'b0;
    id_packet = NOP_PACKET;
    if (bypass) begin
      id_valid  = 1'b1;
      id_packet = if_packet;
    end else if (!empty && entry_vld[head]) begin
      id_valid  = !flush;
      id_packet = mem[head];
    end
    pop = id_valid && id_ready && !bypass;
  end

  // Pointer, occupancy and entry-valid bookkeeping; flush wins over push/pop.
  // ready_en holds fq_ready low until the first edge after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      entry_vld <= '0;
      ready_en  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        entry_vld <= '0;
      end else begin
        // push and pop never address the same slot: that needs empty or full
        if (push) begin
          tail            <= tail + PTR_W'(1);
          entry_vld[tail] <= 1'b1;
        end
        if (pop) begin
          head            <= head + PTR_W'(1);
          entry_vld[head] <= 1'b0;
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Packet storage; contents are qualified by entry_vld so no reset needed.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[tail] <= if_packet;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 8).
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic        clock;
  logic        reset;
  IF_ID_PACKET if_packet;
  logic        fq_ready;
  logic        flush;
  IF_ID_PACKET id_packet;
  logic        id_valid;
  logic        id_ready;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q [$];

  fetch_queue #(.DEPTH(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .if_packet(if_packet),
    .fq_ready (fq_ready),
    .flush    (flush),
    .id_packet(id_packet),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic IF_ID_PACKET mk(input logic [31:0] pc);
    IF_ID_PACKET p;
    p.inst  = 32'h1000_0000 | pc;
    p.PC    = pc;
    p.NPC   = pc + 32'd4;
    p.valid = 1'b1;
    return p;
  endfunction

  // advance one edge and settle 1ns after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    if_packet = NOP_PACKET;
    id_ready  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; id_ready = 1'b0; if_packet = mk(32'h0);
    repeat (3) step();
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rst_id_valid: got %0b expected 0", id_valid); end
    n_cmp++; if (fq_ready !== 1'b0) begin n_bad++; $display("FAIL rst_fq_ready: got %0b expected 0", fq_ready); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL rst_count: got %0d expected 0", count); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL rst_flags: got empty=%0b full=%0b expected 1/0", empty, full); end
    n_cmp++; if (id_packet.inst !== 32'h13 || id_packet.PC !== 32'h0) begin n_bad++; $display("FAIL rst_nop: got inst=%h pc=%h expected 00000013/0", id_packet.inst, id_packet.PC); end
    if_packet = NOP_PACKET;
    reset = 1'b1;
    #1;
    n_cmp++; if (fq_ready !== 1'b0) begin n_bad++; $display("FAIL rel_fq_ready_early: got %0b expected 0", fq_ready); end
    step();
    n_cmp++; if (fq_ready !== 1'b1) begin n_bad++; $display("FAIL rel_fq_ready: got %0b expected 1", fq_ready); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL rel_count: got %0d expected 0", count); end
  endtask

  task automatic test_fill();
    id_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if_packet = mk(32'(4 * i));
      step();
      if (i == 0) begin
        n_cmp++; if (id_valid !== 1'b1 || id_packet.PC !== 32'h0) begin n_bad++; $display("FAIL fill_first_visible: got v=%0b pc=%h expected 1/0", id_valid, id_packet.PC); end
      end
    end
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL fill_count: got %0d expected 8", count); end
    n_cmp++; if (full !== 1'b1 || fq_ready !== 1'b0) begin n_bad++; $display("FAIL fill_full: got full=%0b rdy=%0b expected 1/0", full, fq_ready); end
    if_packet = mk(32'h20);
    step();
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL fill_ninth_count: got %0d expected 8", count); end
    n_cmp++; if (id_packet.PC !== 32'h0 || id_packet.NPC !== 32'h4) begin n_bad++; $display("FAIL fill_head_stable: got pc=%h npc=%h expected 0/4", id_packet.PC, id_packet.NPC); end
    if_packet = NOP_PACKET;
  endtask

  task automatic test_drain();
    id_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (id_valid !== 1'b1 || id_packet.PC !== 32'(4 * i) || id_packet.inst !== (32'h1000_0000 | 32'(4 * i))) begin
        n_bad++; $display("FAIL drain_%0d: got v=%0b pc=%h expected 1/%h", i, id_valid, id_packet.PC, 4 * i);
      end
      step();
    end
    n_cmp++; if (empty !== 1'b1 || id_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got empty=%0b v=%0b expected 1/0", empty, id_valid); end
    n_cmp++; if (id_packet.inst !== 32'h13) begin n_bad++; $display("FAIL drain_nop: got %h expected 00000013", id_packet.inst); end
    id_ready = 1'b0;
  endtask

  // head/tail start at 0 here; push 6, pop 2 -> head 2, tail 6, then
  // 6 cycles of push+pop carry both pointers across the 7->0 wrap
  task automatic test_back_to_back();
    logic [31:0] pc;
    exp_q.delete();
    id_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pc = 32'h200 + 32'(4 * i); if_packet = mk(pc); exp_q.push_back(pc); step();
    end
    if_packet = NOP_PACKET; id_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin void'(exp_q.pop_front()); step(); end
    n_cmp++; if (count !== 4'd4) begin n_bad++; $display("FAIL b2b_pre_count: got %0d expected 4", count); end
    for (int i = 0; i < 6; i++) begin
      pc = 32'h300 + 32'(4 * i); if_packet = mk(pc);
      #1;
      n_cmp++; if (id_packet.PC !== exp_q[0]) begin n_bad++; $display("FAIL b2b_order_%0d: got %h expected %h", i, id_packet.PC, exp_q[0]); end
      void'(exp_q.pop_front()); exp_q.push_back(pc);
      step();
      n_cmp++; if (count !== 4'd4) begin n_bad++; $display("FAIL b2b_count_%0d: got %0d expected 4", i, count); end
    end
    if_packet = NOP_PACKET;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (id_valid !== 1'b1 || id_packet.PC !== exp_q[0]) begin n_bad++; $display("FAIL b2b_tail_%0d: got v=%0b pc=%h expected 1/%h", i, id_valid, id_packet.PC, exp_q[0]); end
      void'(exp_q.pop_front());
      step();
    end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL b2b_empty: got %0b expected 1", empty); end
    id_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin if_packet = mk(32'h400 + 32'(4 * i)); step(); end
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL flush_pre_count: got %0d expected 5", count); end
    if_packet = mk(32'h500); id_ready = 1'b1; flush = 1'b1;
    #1;
    n_cmp++; if (id_valid !== 1'b0 || fq_ready !== 1'b0) begin n_bad++; $display("FAIL flush_cycle: got v=%0b rdy=%0b expected 0/0", id_valid, fq_ready); end
    step();
    flush = 1'b0; if_packet = NOP_PACKET; id_ready = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd0 || id_valid !== 1'b0 || empty !== 1'b1) begin n_bad++; $display("FAIL flush_after: got cnt=%0d v=%0b e=%0b expected 0/0/1", count, id_valid, empty); end
    if_packet = mk(32'h100);
    step();
    if_packet = NOP_PACKET;
    n_cmp++; if (count !== 4'd1 || id_valid !== 1'b1 || id_packet.PC !== 32'h100) begin n_bad++; $display("FAIL flush_redirect: got cnt=%0d v=%0b pc=%h expected 1/1/100", count, id_valid, id_packet.PC); end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    n_cmp++; if (count !== 4'd0 || id_valid !== 1'b0) begin n_bad++; $display("FAIL flush_redirect_pop: got cnt=%0d v=%0b expected 0/0", count, id_valid); end
    // two-cycle flush with a packet offered the whole time
    if_packet = mk(32'h600); flush = 1'b1;
    step(); step();
    flush = 1'b0; if_packet = NOP_PACKET;
    #1;
    n_cmp++; if (count !== 4'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL flush_multi: got cnt=%0d e=%0b expected 0/1", count, empty); end
  endtask

  task automatic test_async_reset();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin if_packet = mk(32'h700 + 32'(4 * i)); step(); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd0 || empty !== 1'b1 || id_valid !== 1'b0 || fq_ready !== 1'b0) begin n_bad++; $display("FAIL async_reset: got cnt=%0d e=%0b v=%0b rdy=%0b expected 0/1/0/0", count, empty, id_valid, fq_ready); end
    if_packet = NOP_PACKET;
    step();
    reset = 1'b1;
    step();
    n_cmp++; if (fq_ready !== 1'b1 || count !== 4'd0) begin n_bad++; $display("FAIL async_release: got rdy=%0b cnt=%0d expected 1/0", fq_ready, count); end
  endtask

  task automatic test_bypass();
    if_packet = mk(32'h40); id_ready = 1'b1;
    #1;
`ifdef FQ_BYPASS_EN
    n_cmp++; if (id_valid !== 1'b1 || id_packet.PC !== 32'h40) begin n_bad++; $display("FAIL bypass_same_cycle: got v=%0b pc=%h expected 1/40", id_valid, id_packet.PC); end
    step();
    if_packet = NOP_PACKET;
    #1;
    n_cmp++; if (count !== 4'd0 || id_valid !== 1'b0) begin n_bad++; $display("FAIL bypass_count: got cnt=%0d v=%0b expected 0/0", count, id_valid); end
`else
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL nobypass_same_cycle: got v=%0b expected 0", id_valid); end
    step();
    if_packet = NOP_PACKET;
    #1;
    n_cmp++; if (count !== 4'd1 || id_valid !== 1'b1 || id_packet.PC !== 32'h40) begin n_bad++; $display("FAIL nobypass_next: got cnt=%0d v=%0b pc=%h expected 1/1/40", count, id_valid, id_packet.PC); end
    step();
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL nobypass_pop: got cnt=%0d expected 0", count); end
`endif
    id_ready = 1'b0;
  endtask

  initial begin
    idle_in();
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
